rcpt_ptw_walker: RTL and testbench

//  Range page-table walker. Serves one TLB miss at a time by reading range entries
//  {ATT,PPN,SVPN_END,SVPN} linearly from a memory-resident table at i_ptbr.
//  On a range hit it drives the TLB-line update bus (o_ptwUpdate/VPN/VPN_END/PPN/ATT).

---
 rtl/rcpt_ptw_walker.sv | 251 +++++++++++++++++++++++++
 tb/tb_rcpt_ptw_walker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcpt_ptw_walker.sv
// ============================================================================
// rcpt_ptw_walker
// ----------------------------------------------------------------------------
// Range page-table walker. Serves one TLB miss at a time. It reads range
// entries {ATT, PPN, SVPN_END, SVPN} one by one from a memory-resident table
// that starts at i_ptbr. When the faulting VPN falls inside an entry's range
// [SVPN, SVPN_END), the walker drives the TLB-line update bus for one cycle.
// If no entry matches after num_entries reads, it pulses o_fault.
//
// Optional feature (build macro PTW_HINT_START_EN):
//   When the macro is defined, each walk starts at the index of the last hit
//   (the hint) and not at entry 0. The walk wraps to 0 at num_entries and
//   still makes at most num_entries reads. A hint that is out of range for
//   the current table is treated as 0. When the macro is undefined, every
//   walk starts at index 0 and no hint register exists.
//
// Ports
//   i_clk, i_rst_n       clock; asynchronous active-low reset
//   i_miss_req           miss request, accepted while o_miss_ready=1
//   i_miss_VPN           faulting VPN (sampled on accept)
//   o_miss_ready         high only while idle
//   i_ptbr               table base byte address (sampled on accept)
//   i_num_entries        number of valid table entries (sampled on accept)
//   o_mem_req            read request, held until i_mem_ack
//   o_mem_addr           i_ptbr + idx*ENTRY_STRIDE (truncated)
//   i_mem_ack            read request accepted
//   i_mem_rvalid         read data valid (one beat per request)
//   i_mem_rdata          {ATT, PPN, SVPN_END, SVPN}, SVPN in the LSBs
//   o_ptwUpdate          one-cycle TLB-line update pulse
//   o_ptwVPN/_VPN_END/o_ptwPPN/o_ptwATT  fields of the last hit entry
//   o_done               one-cycle pulse: the walk ended with a hit
//   o_fault              one-cycle pulse: the walk ended with no match
//   o_busy               walker not idle
// ============================================================================
module rcpt_ptw_walker #(
   parameter int ADDR_WIDTH   = 35,
   parameter int VPN_WIDTH    = 23,
   parameter int PPN_WIDTH    = 23,
   parameter int ATT_WIDTH    = 10,
   parameter int IDX_WIDTH    = 8,
   parameter int ENTRY_STRIDE = 16
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic                                      i_miss_req,
   input  logic [VPN_WIDTH-1:0]                      i_miss_VPN,
   output logic                                      o_miss_ready,
   input  logic [ADDR_WIDTH-1:0]                     i_ptbr,
   input  logic [IDX_WIDTH-1:0]                      i_num_entries,
   output logic                                      o_mem_req,
   output logic [ADDR_WIDTH-1:0]                     o_mem_addr,
   input  logic                                      i_mem_ack,
   input  logic                                      i_mem_rvalid,
   input  logic [2*VPN_WIDTH+PPN_WIDTH+ATT_WIDTH-1:0] i_mem_rdata,
   output logic                                      o_ptwUpdate,
   output logic [VPN_WIDTH-1:0]                      o_ptwVPN,
   output logic [VPN_WIDTH-1:0]                      o_ptwVPN_END,
   output logic [PPN_WIDTH-1:0]                      o_ptwPPN,
   output logic [ATT_WIDTH-1:0]                      o_ptwATT,
   output logic                                      o_done,
   output logic                                      o_fault,
   output logic                                      o_busy
);

   localparam int DATA_WIDTH = 2*VPN_WIDTH + PPN_WIDTH + ATT_WIDTH;

   // Bit positions of the fields inside one table entry
   localparam int SVPN_LSB = 0;
   localparam int SEND_LSB = VPN_WIDTH;
   localparam int PPN_LSB  = 2*VPN_WIDTH;
   localparam int ATT_LSB  = 2*VPN_WIDTH + PPN_WIDTH;

   localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};
   localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1'b1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_UPDATE = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   // Byte address of entry idx. The sum wraps at ADDR_WIDTH bits.
   function automatic logic [ADDR_WIDTH-1:0] entry_addr(
      input logic [ADDR_WIDTH-1:0] base,
      input logic [IDX_WIDTH-1:0]  idx
   );
      entry_addr = base + (ADDR_WIDTH'(idx) * ADDR_WIDTH'(ENTRY_STRIDE));
   endfunction

   state_t                  state_q;
   logic [VPN_WIDTH-1:0]    vpn_q;
   logic [ADDR_WIDTH-1:0]   ptbr_q;
   logic [IDX_WIDTH-1:0]    num_q;
   logic [IDX_WIDTH-1:0]    idx_q;
   logic [IDX_WIDTH-1:0]    count_q;
   logic [DATA_WIDTH-1:0]   entry_q;

   logic [VPN_WIDTH-1:0]    ent_svpn_s;
   logic [VPN_WIDTH-1:0]    ent_send_s;
   logic [PPN_WIDTH-1:0]    ent_ppn_s;
   logic [ATT_WIDTH-1:0]    ent_att_s;
   logic                    hit_s;
   logic [IDX_WIDTH-1:0]    count_inc_s;
   logic [IDX_WIDTH-1:0]    idx_inc_s;
   logic [IDX_WIDTH-1:0]    idx_d;
   logic [IDX_WIDTH-1:0]    start_idx_d;

   assign ent_svpn_s = entry_q[SVPN_LSB +: VPN_WIDTH];
   assign ent_send_s = entry_q[SEND_LSB +: VPN_WIDTH];
   assign ent_ppn_s  = entry_q[PPN_LSB  +: PPN_WIDTH];
   assign ent_att_s  = entry_q[ATT_LSB  +: ATT_WIDTH];

   // The hit test uses the range only, with no check on ATT. An entry with
   // SVPN_END <= SVPN is empty and can never hit.
   assign hit_s = (vpn_q >= ent_svpn_s) && (vpn_q < ent_send_s);

   assign count_inc_s = count_q + IDX_ONE;
   assign idx_inc_s   = idx_q + IDX_ONE;
   // The next entry index wraps to 0 at the table size. This matters only
   // when a walk starts part-way into the table.
   assign idx_d       = (idx_inc_s == num_q) ? IDX_ZERO : idx_inc_s;

`ifdef PTW_HINT_START_EN
   logic [IDX_WIDTH-1:0]    hint_q;
   // A stale hint from a larger table must not point past the current table.
   assign start_idx_d = (hint_q >= i_num_entries) ? IDX_ZERO : hint_q;
`else
   assign start_idx_d = IDX_ZERO;
`endif

   // Walker FSM with all outputs registered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         vpn_q        <= {VPN_WIDTH{1'b0}};
         ptbr_q       <= {ADDR_WIDTH{1'b0}};
         num_q        <= IDX_ZERO;
         idx_q        <= IDX_ZERO;
         count_q      <= IDX_ZERO;
         entry_q      <= {DATA_WIDTH{1'b0}};
         o_miss_ready <= 1'b1;
         o_busy       <= 1'b0;
         o_mem_req    <= 1'b0;
         o_mem_addr   <= {ADDR_WIDTH{1'b0}};
         o_ptwUpdate  <= 1'b0;
         o_ptwVPN     <= {VPN_WIDTH{1'b0}};
         o_ptwVPN_END <= {VPN_WIDTH{1'b0}};
         o_ptwPPN     <= {PPN_WIDTH{1'b0}};
         o_ptwATT     <= {ATT_WIDTH{1'b0}};
         o_done       <= 1'b0;
         o_fault      <= 1'b0;
`ifdef PTW_HINT_START_EN
         hint_q       <= IDX_ZERO;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               // o_miss_ready is high in this state, so a request is accepted at once
               if (i_miss_req) begin
                  vpn_q        <= i_miss_VPN;
                  ptbr_q       <= i_ptbr;
                  num_q        <= i_num_entries;
                  count_q      <= IDX_ZERO;
                  o_miss_ready <= 1'b0;
                  o_busy       <= 1'b1;
                  if (i_num_entries == IDX_ZERO) begin
                     // An empty table faults right away and makes no memory read
                     state_q <= ST_FAULT;
                     o_fault <= 1'b1;
                  end else begin
                     state_q    <= ST_REQ;
                     idx_q      <= start_idx_d;
                     o_mem_req  <= 1'b1;
                     o_mem_addr <= entry_addr(i_ptbr, start_idx_d);
                  end
               end
            end

            ST_REQ: begin
               // The request and address stay stable until the memory accepts
               if (i_mem_ack) begin
                  o_mem_req <= 1'b0;
                  state_q   <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (i_mem_rvalid) begin
                  entry_q <= i_mem_rdata;
                  state_q <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               if (hit_s) begin
                  state_q      <= ST_UPDATE;
                  o_ptwUpdate  <= 1'b1;
                  o_done       <= 1'b1;
                  o_ptwVPN     <= ent_svpn_s;
                  o_ptwVPN_END <= ent_send_s;
                  o_ptwPPN     <= ent_ppn_s;
                  o_ptwATT     <= ent_att_s;
`ifdef PTW_HINT_START_EN
                  hint_q       <= idx_q;
`endif
               end else if (count_inc_s == num_q) begin
                  // Every entry has been read once with no match
                  state_q <= ST_FAULT;
                  o_fault <= 1'b1;
               end else begin
                  count_q    <= count_inc_s;
                  idx_q      <= idx_d;
                  o_mem_req  <= 1'b1;
                  o_mem_addr <= entry_addr(ptbr_q, idx_d);
                  state_q    <= ST_REQ;
               end
            end

            ST_UPDATE: begin
               o_ptwUpdate  <= 1'b0;
               o_done       <= 1'b0;
               o_miss_ready <= 1'b1;
               o_busy       <= 1'b0;
               state_q      <= ST_IDLE;
            end

            ST_FAULT: begin
               o_fault      <= 1'b0;
               o_miss_ready <= 1'b1;
               o_busy       <= 1'b0;
               state_q      <= ST_IDLE;
            end

            default: begin
               // Recover from an illegal state code to a clean idle
               state_q      <= ST_IDLE;
               o_mem_req    <= 1'b0;
               o_ptwUpdate  <= 1'b0;
               o_done       <= 1'b0;
               o_fault      <= 1'b0;
               o_miss_ready <= 1'b1;
               o_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rcpt_ptw_walker.sv
// ============================================================================
// tb_rcpt_ptw_walker
// Directed self-checking bench for rcpt_ptw_walker. A small memory responder
// accepts requests at once (unless ack_block is set) and returns the table
// entry one cycle later. All expected values are written out by hand.
// ============================================================================
`timescale 1ns/1ps
module tb_rcpt_ptw_walker;

   logic        clk;
   logic        rst_n;
   logic        miss_req;
   logic [22:0] miss_vpn;
   logic        miss_ready_o;
   logic [34:0] ptbr;
   logic [7:0]  num;
   logic        mem_req_o;
   logic [34:0] mem_addr_o;
   logic        mem_ack;
   logic        mem_rvalid;
   logic [78:0] mem_rdata;
   logic        upd_o;
   logic [22:0] ptw_vpn_o;
   logic [22:0] ptw_end_o;
   logic [22:0] ptw_ppn_o;
   logic [9:0]  ptw_att_o;
   logic        done_o;
   logic        fault_o;
   logic        busy_o;

   logic        ack_block = 1'b0;
   logic        stray_rv = 1'b0;
   logic        rv_q = 1'b0;
   logic [78:0] rdata_q = '0;
   logic [34:0] log_addr [0:255];
   int          nreads = 0;
   int          done_cnt = 0;
   int          fault_cnt = 0;
   int          upd_cnt = 0;
   int          req_cyc = 0;

   logic [78:0] tbl [0:3];
   int          tests = 0;
   int          fails = 0;
   int          hint_m = 0;
   logic [22:0] last_vpn = '0, last_end = '0, last_ppn = '0;
   logic [9:0]  last_att = '0;

   rcpt_ptw_walker dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_miss_req(miss_req), .i_miss_VPN(miss_vpn), .o_miss_ready(miss_ready_o),
      .i_ptbr(ptbr), .i_num_entries(num),
      .o_mem_req(mem_req_o), .o_mem_addr(mem_addr_o), .i_mem_ack(mem_ack),
      .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
      .o_ptwUpdate(upd_o), .o_ptwVPN(ptw_vpn_o), .o_ptwVPN_END(ptw_end_o),
      .o_ptwPPN(ptw_ppn_o), .o_ptwATT(ptw_att_o),
      .o_done(done_o), .o_fault(fault_o), .o_busy(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_ack    = mem_req_o & ~ack_block;
   assign mem_rvalid = rv_q | stray_rv;
   assign mem_rdata  = rdata_q;

   function automatic logic [78:0] lookup(input logic [34:0] a);
      logic [34:0] off;
      off = a - ptbr;
      if (off[3:0] == 4'd0 && off[34:6] == '0) lookup = tbl[off[5:4]];
      else lookup = '0;
   endfunction

   // Memory responder, read log and pulse counters
   always @(posedge clk) begin
      if (mem_req_o && mem_ack) begin
         log_addr[nreads[7:0]] <= mem_addr_o;
         nreads  <= nreads + 1;
         rv_q    <= 1'b1;
         rdata_q <= lookup(mem_addr_o);
      end else begin
         rv_q <= 1'b0;
      end
      if (done_o)    done_cnt  <= done_cnt + 1;
      if (fault_o)   fault_cnt <= fault_cnt + 1;
      if (upd_o)     upd_cnt   <= upd_cnt + 1;
      if (mem_req_o) req_cyc   <= req_cyc + 1;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " ready"}, miss_ready_o, 1'b1);
      check({tag, " busy"}, busy_o, 1'b0);
      check({tag, " mem_req"}, mem_req_o, 1'b0);
      check({tag, " pulses"}, {upd_o, done_o, fault_o}, 3'b000);
   endtask

   task automatic check_fields(input string tag);
      check({tag, " ptwVPN"}, ptw_vpn_o, last_vpn);
      check({tag, " ptwVPN_END"}, ptw_end_o, last_end);
      check({tag, " ptwPPN"}, ptw_ppn_o, last_ppn);
      check({tag, " ptwATT"}, ptw_att_o, last_att);
   endtask

   task automatic set_last(input int i);
      logic [78:0] e;
      e = tbl[i];
      last_vpn = e[22:0];
      last_end = e[45:23];
      last_ppn = e[68:46];
      last_att = e[78:69];
`ifdef PTW_HINT_START_EN
      hint_m = i;
`endif
   endtask

   // Present a miss and return once the accepting edge has passed
   task automatic start_miss(input string tag, input logic [22:0] vpn);
      @(negedge clk);
      check({tag, " ready before accept"}, miss_ready_o, 1'b1);
      miss_vpn = vpn;
      miss_req = 1'b1;
      @(posedge clk);
      #1 miss_req = 1'b0;
   endtask

   task automatic do_walk(input string tag, input logic [22:0] vpn, input logic [7:0] n,
                          input bit hit, input int hidx);
      int start, nr, n0, d0, f0, u0, r0, cyc;
      bit ended;
      start = (hint_m >= int'(n)) ? 0 : hint_m;
      if (n == 8'd0) nr = 0;
      else if (hit) nr = ((hidx - start + int'(n)) % int'(n)) + 1;
      else nr = int'(n);
      n0 = nreads; d0 = done_cnt; f0 = fault_cnt; u0 = upd_cnt; r0 = req_cyc;
      num = n;
      start_miss(tag, vpn);
      cyc = 0;
      ended = 1'b0;
      while (!ended && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done_o || fault_o) ended = 1'b1;
      end
      check({tag, " ended"}, ended, 1'b1);
      check({tag, " latency"}, cyc, 1 + 3*nr);
      check({tag, " update with done"}, upd_o, hit);
      @(negedge clk);
      check({tag, " pulse one cycle"}, {upd_o, done_o, fault_o}, 3'b000);
      check({tag, " reads"}, nreads - n0, nr);
      for (int k = 0; k < nr; k++)
         check($sformatf("%s addr%0d", tag, k), log_addr[(n0+k) % 256],
               ptbr + 35'(((start + k) % int'(n)) * 16));
      if (nr == 0) check({tag, " no mem_req"}, req_cyc - r0, 0);
      check({tag, " done count"}, done_cnt - d0, hit ? 1 : 0);
      check({tag, " fault count"}, fault_cnt - f0, hit ? 0 : 1);
      check({tag, " update count"}, upd_cnt - u0, hit ? 1 : 0);
      if (hit) set_last(hidx);
      check_fields(tag);
      check_idle(tag);
   endtask

   initial begin
      int start, cyc, u0, d0;
      bit ended;
      // entry = {ATT, PPN, SVPN_END, SVPN}
      tbl[0] = {10'h3FF, 23'h200, 23'h20, 23'h10};
      tbl[1] = {10'h001, 23'h250, 23'h38, 23'h30};
      tbl[2] = {10'h155, 23'h300, 23'h50, 23'h40};
      tbl[3] = {10'h0AA, 23'h350, 23'h60, 23'h70};   // empty range
      rst_n = 1'b0; miss_req = 1'b0; miss_vpn = '0; ptbr = 35'h1000; num = 8'd4;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check_fields("reset");
      check("reset mem_addr", mem_addr_o, 35'h0);
      rst_n = 1'b1;
      @(negedge clk);

      do_walk("hit e0", 23'h15, 8'd4, 1'b1, 0);
      do_walk("hit e0 low edge", 23'h10, 8'd4, 1'b1, 0);
      do_walk("hit e2", 23'h48, 8'd4, 1'b1, 2);
      do_walk("miss at END", 23'h20, 8'd4, 1'b0, 0);
      do_walk("empty range", 23'h75, 8'd4, 1'b0, 0);
      do_walk("num zero", 23'h15, 8'd0, 1'b0, 0);

      // Delayed ack: the request must hold; a second miss is ignored
      start = (hint_m >= 4) ? 0 : hint_m;
      u0 = upd_cnt; d0 = done_cnt;
      ack_block = 1'b1;
      num = 8'd4;
      start_miss("held", 23'h15);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("held req c%0d", k), mem_req_o, 1'b1);
         check($sformatf("held addr c%0d", k), mem_addr_o, ptbr + 35'(start * 16));
         if (k == 1) begin
            check("busy ready low", miss_ready_o, 1'b0);
            miss_vpn = 23'h48;
            miss_req = 1'b1;
         end
         if (k == 3) miss_req = 1'b0;
      end
      ack_block = 1'b0;
      cyc = 0; ended = 1'b0;
      while (!ended && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done_o || fault_o) ended = 1'b1;
      end
      check("held ended", ended, 1'b1);
      check("held done", done_o, 1'b1);
      @(negedge clk);
      check("held update count", upd_cnt - u0, 1);
      check("held done count", done_cnt - d0, 1);
      set_last(0);
      check_fields("held");
      check_idle("held");

      // Reset during WAIT, then a stray rvalid
      u0 = upd_cnt; d0 = done_cnt + fault_cnt;
      start_miss("rst", 23'h48);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      check_idle("in reset");
      rst_n = 1'b1;
      hint_m = 0;
      last_vpn = '0; last_end = '0; last_ppn = '0; last_att = '0;
      @(negedge clk);
      stray_rv = 1'b1;
      @(negedge clk);
      stray_rv = 1'b0;
      repeat (4) @(negedge clk);
      check_idle("after stray");
      check_fields("after stray");
      check("stray no update", upd_cnt - u0, 0);
      check("stray no done/fault", done_cnt + fault_cnt - d0, 0);

      // Hint behaviour: hit entry2, then a miss that lands in entry1
      do_walk("hint e2", 23'h48, 8'd4, 1'b1, 2);
      do_walk("hint e1", 23'h34, 8'd4, 1'b1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
